delay_pipe_arbiter: RTL and testbench
=====================================

# delay_pipe_arbiter

Round-robin arbiter and sequencer that shares one fixed-latency 32-bit delay pipeline (the DELAY-stage, non-stallable shifter used in the ORAM obfuscation path) among NUM_REQ requesters. It issues at most one word per cycle into the pipeline. It carries a shadow tag pipeline of the same depth, so every result emerging DELAY cycles later is routed back to the requester that issued it. It also counts in-flight words and flags misalignment between the data pipeline and its shadow tags.

## Interface
- NUM_REQ, 4: number of requesters, 2..16.
- DELAY, 4: latency of the attached pipeline in cycles, ≥2; must match the pipeline instance.
- TAG_W, $clog2(NUM_REQ): requester index width.
- CNT_W, $clog2(DELAY+2): in-flight counter width.
- Clock  in  1  sole clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Enable  in  1  issue permitted this cycle; responses are always routed regardless.
- ReqValid  in  NUM_REQ  per-requester word available.
- ReqData  in  32*NUM_REQ  requester i word at bits [32*i+31:32*i].
- ReqReady  out  NUM_REQ  one-hot grant, combinational; the word is consumed in this cycle.
- PipeInData  out  32  registered word to pipeline input.
- PipeInValid  out  1  registered valid to pipeline input.
- PipeOutData  in  32  pipeline output word.
- PipeOutValid  in  1  pipeline output valid.
- RespValid  out  NUM_REQ  registered one-hot response strobe.
- RespData  out  32  registered response word.
- InFlight  out  CNT_W  real words issued and not yet responded.
- Busy  out  1  InFlight != 0.
- Error  out  1  sticky tag/data misalignment flag.

## Operation
- Grant: when Enable=1, scan ReqValid starting at pointer Ptr, upward with wrap. The first set bit g gets ReqReady[g]=1. No grant when Enable=0 or ReqValid=0.
- Ptr update: on a grant, Ptr <= (g+1) mod NUM_REQ. Otherwise Ptr is held. Ptr resets to 0.
- Issue register: each cycle, PipeInData/PipeInValid <= the granted word and 1, else PipeInData holds and PipeInValid <= 0. The shadow tag stage 0 <= {v, dummy, g}, loaded at the same edge as PipeInValid.
- Shadow tag pipeline: DELAY stages that shift every cycle unconditionally. The head is aligned with PipeOutValid.
- Response: when PipeOutValid=1, head v=1 and head dummy=0, then on the next edge RespValid <= one-hot(head tag) and RespData <= PipeOutData. Otherwise RespValid <= 0 and RespData holds. Requesters cannot backpressure.
- InFlight: +1 on a real issue (PipeInValid load with dummy=0), −1 when a real response is loaded. Both in the same cycle leaves it unchanged. It never exceeds DELAY+1.
- Warm-up: a counter runs DELAY cycles after reset deassertion. During warm-up, PipeOutValid is ignored, because the pipeline has no reset and may hold stale data.
- Error: after warm-up, it is set when PipeOutValid != head v. It remains set until reset and does not block operation.
- Reset mid-operation: all tags, RespValid, PipeInValid, InFlight, Ptr and warm-up are cleared immediately. Words already in the pipeline are dropped without a response and without setting Error.

## Timing
- Reset values: ReqReady=0, PipeInData=0, PipeInValid=0, RespValid=0, RespData=0, InFlight=0, Busy=0, Error=0.
- Grant at cycle t gives PipeInValid=1 at t+1, PipeOutValid at t+1+DELAY, and RespValid at t+2+DELAY. End-to-end latency is DELAY+2.
- Throughput is one issue per cycle. With all requesters valid, grants rotate 0,1,…,NUM_REQ−1,0.
- Enable=0 stops issue only. In-flight words still return at their normal slots.

## Configuration
- OBLIV_DUMMY_EN defined: when Enable=1 and no requester is valid, issue a dummy word: PipeInData=0, PipeInValid=1, tag dummy=1. The pipeline then sees a constant issue rate independent of access pattern. Dummy results produce no RespValid and do not count in InFlight. Error checking still covers dummy slots (v=1).
- OBLIV_DUMMY_EN undefined: idle cycles issue PipeInValid=0, and the dummy tag bit is tied to 0.

## Test plan
- Single request: after warm-up, ReqValid=4'b0100, ReqData[95:64]=32'hDEADBEEF at cycle t. Expect ReqReady=4'b0100 at t, PipeInValid at t+1, and RespValid=4'b0100 with RespData=32'hDEADBEEF at t+2+DELAY. InFlight goes 0→1→0.
- Fairness: all ReqValid held high for 8 cycles. Expect grants 0,1,2,3,0,1,2,3, responses in the same order back-to-back, and peak InFlight=DELAY+1.
- Enable gating: Enable=0 while requests are pending. Expect no ReqReady and PipeInValid=0. Words already issued still respond on schedule.
- Misalignment: after warm-up, force PipeOutValid=1 with no issued word. Expect Error=1 on the next edge, staying set; RespValid stays 0.
- Reset mid-flight: assert Reset_n=0 with 3 words in flight. Expect immediate InFlight=0 and RespValid=0. After release, the pipeline's stale outputs during warm-up produce no response and no Error.
- Dummy mode (OBLIV_DUMMY_EN): idle with Enable=1. Expect PipeInValid=1 every cycle with PipeInData=0, no RespValid, InFlight=0 and Error=0.

Source files
------------

// File: rtl/delay_pipe_arbiter_if.sv
// Requester-side bus of delay_pipe_arbiter: word offers, one-hot grants and
// routed responses coming back from the shared delay pipeline.
interface delay_pipe_arbiter_if #(
   parameter int NUM_REQ = 4
) ();
   logic [NUM_REQ-1:0]    ReqValid;
   logic [32*NUM_REQ-1:0] ReqData;
   logic [NUM_REQ-1:0]    ReqReady;
   logic [NUM_REQ-1:0]    RespValid;
   logic [31:0]           RespData;

   modport master (output ReqValid, ReqData, input ReqReady, RespValid, RespData);
   modport slave  (input ReqValid, ReqData, output ReqReady, RespValid, RespData);
endinterface

// File: rtl/delay_pipe_arbiter.sv
// Round-robin issue into a shared fixed-latency delay pipeline, with a shadow tag
// pipeline routing results home. OBLIV_DUMMY_EN adds dummy issues on idle cycles.
module delay_pipe_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DELAY   = 4,
   parameter int TAG_W   = $clog2(NUM_REQ),
   parameter int CNT_W   = $clog2(DELAY+2)
) (
   input  logic             Clock,
   input  logic             Reset_n,
   input  logic             Enable,
   delay_pipe_arbiter_if.slave req_bus,
   output logic [31:0]      PipeInData,
   output logic             PipeInValid,
   input  logic [31:0]      PipeOutData,
   input  logic             PipeOutValid,
   output logic [CNT_W-1:0] InFlight,
   output logic             Busy,
   output logic             Error
);

   typedef struct packed {
      logic             v;
      logic             dummy;
      logic [TAG_W-1:0] id;
   } tag_t;

   logic [TAG_W-1:0]   ptr;
   logic [TAG_W-1:0]   grant_idx;
   logic               grant_any;
   logic [TAG_W:0]     scan_cand;
   logic [NUM_REQ-1:0] grant;
   logic [31:0]        grant_word;
   logic               dummy_issue;
   tag_t               shadow [0:DELAY];
   tag_t               head;
   logic [CNT_W-1:0]   warm_cnt;
   logic               warm_done;
   logic               resp_fire;
   logic [NUM_REQ-1:0] resp_valid_q;
   logic [31:0]        resp_data_q;

   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      scan_cand = '0;
      if (Enable) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            scan_cand = {1'b0, ptr} + (TAG_W+1)'(k);
            if (scan_cand >= (TAG_W+1)'(NUM_REQ)) scan_cand = scan_cand - (TAG_W+1)'(NUM_REQ);
            if (!grant_any && req_bus.ReqValid[scan_cand[TAG_W-1:0]]) begin
               grant_any = 1'b1;
               grant_idx = scan_cand[TAG_W-1:0];
            end
         end
      end
   end

   always_comb begin
      grant_word = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_idx == TAG_W'(i)) grant_word = req_bus.ReqData[32*i +: 32];
      end
   end

   assign grant           = grant_any ? (NUM_REQ'(1) << grant_idx) : '0;
   assign req_bus.ReqReady = grant;

`ifdef OBLIV_DUMMY_EN
   // Keep the pipeline issue rate constant regardless of the access pattern.
   assign dummy_issue = Enable && (req_bus.ReqValid == '0);
`else
   assign dummy_issue = 1'b0;
`endif

   // Stale pipeline contents after reset drain out during the first DELAY cycles.
   assign head      = shadow[DELAY];
   assign warm_done = (warm_cnt == '0);
   assign resp_fire = warm_done && PipeOutValid && head.v && !head.dummy;

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         ptr          <= '0;
         PipeInData   <= '0;
         PipeInValid  <= 1'b0;
         for (int s = 0; s <= DELAY; s++) shadow[s] <= '0;
         warm_cnt     <= CNT_W'(DELAY);
         resp_valid_q <= '0;
         resp_data_q  <= '0;
         InFlight     <= '0;
         Error        <= 1'b0;
      end else begin
         if (grant_any) ptr <= (grant_idx == TAG_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;

         PipeInValid <= grant_any || dummy_issue;
         if (grant_any)        PipeInData <= grant_word;
         else if (dummy_issue) PipeInData <= '0;

         shadow[0] <= '{v: grant_any || dummy_issue, dummy: dummy_issue, id: grant_idx};
         for (int s = 1; s <= DELAY; s++) shadow[s] <= shadow[s-1];

         if (!warm_done) warm_cnt <= warm_cnt - 1'b1;

         resp_valid_q <= resp_fire ? (NUM_REQ'(1) << head.id) : '0;
         if (resp_fire) resp_data_q <= PipeOutData;

         if (grant_any && !resp_fire)      InFlight <= InFlight + 1'b1;
         else if (!grant_any && resp_fire) InFlight <= InFlight - 1'b1;

         if (warm_done && (PipeOutValid != head.v)) Error <= 1'b1;
      end
   end

   assign req_bus.RespValid = resp_valid_q;
   assign req_bus.RespData  = resp_data_q;
   assign Busy              = (InFlight != '0);

endmodule

// File: tb/tb_delay_pipe_arbiter.sv
// Bench for delay_pipe_arbiter: grant table, hand-written corner sequences and a
// randomized run against a queue-based model of issue/response timing.
module tb_delay_pipe_arbiter;
   localparam int NUM_REQ = 4;
   localparam int DELAY   = 4;
   localparam int CNT_W   = $clog2(DELAY+2);
`ifdef OBLIV_DUMMY_EN
   localparam bit DUMMY = 1'b1;
`else
   localparam bit DUMMY = 1'b0;
`endif

   logic             Clock   = 1'b0;
   logic             Reset_n = 1'b0;
   logic             Enable  = 1'b0;
   logic [31:0]      PipeInData;
   logic             PipeInValid;
   logic [31:0]      PipeOutData;
   logic             PipeOutValid;
   logic [CNT_W-1:0] InFlight;
   logic             Busy;
   logic             Error;
   logic             force_ov     = 1'b0;
   logic             stale_inject = 1'b0;
   logic [32:0]      pipe [0:DELAY-1];

   delay_pipe_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

   delay_pipe_arbiter #(.NUM_REQ(NUM_REQ), .DELAY(DELAY)) dut (
      .Clock        (Clock),
      .Reset_n      (Reset_n),
      .Enable       (Enable),
      .req_bus      (bus),
      .PipeInData   (PipeInData),
      .PipeInValid  (PipeInValid),
      .PipeOutData  (PipeOutData),
      .PipeOutValid (PipeOutValid),
      .InFlight     (InFlight),
      .Busy         (Busy),
      .Error        (Error)
   );

   always #5 Clock = ~Clock;

   // The attached pipeline: no reset, optionally filled with valid garbage.
   always @(posedge Clock) begin
      pipe[0] <= stale_inject ? {1'b1, 32'($urandom)} : {PipeInValid, PipeInData};
      for (int s = 1; s < DELAY; s++) pipe[s] <= pipe[s-1];
   end
   assign PipeOutValid = pipe[DELAY-1][32] | force_ov;
   assign PipeOutData  = pipe[DELAY-1][31:0];

   typedef struct {
      int                 due;
      int                 idx;
      logic [31:0]        data;
   } resp_t;

   typedef struct {
      logic               en;
      logic [NUM_REQ-1:0] rv;
      logic [NUM_REQ-1:0] exp_ready;
   } vec_t;

   int                 total = 0;
   int                 bad   = 0;
   int                 n     = 0;
   int                 m_ptr = 0;
   int                 m_inflight = 0;
   logic [31:0]        m_pin_data  = '0;
   logic [31:0]        m_resp_data = '0;
   logic               m_err = 1'b0;
   resp_t              q [$];
   logic [NUM_REQ-1:0] last_ready;
   int                 peak = 0;
   vec_t               tbl [8];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", nm, act, exp, n, $time);
      end
   endtask

   task automatic model_clear();
      q.delete();
      n = 0; m_ptr = 0; m_inflight = 0;
      m_pin_data = '0; m_resp_data = '0; m_err = 1'b0;
   endtask

   // One clock: drive inputs, check the combinational grant, then check registered outputs.
   task automatic step(input logic en, input logic [NUM_REQ-1:0] rv, input logic [32*NUM_REQ-1:0] rd);
      logic [NUM_REQ-1:0] eg;
      logic               found;
      int                 gi;
      logic               exp_piv;
      logic [NUM_REQ-1:0] exp_rv;
      Enable = en; bus.ReqValid = rv; bus.ReqData = rd;
      #1;
      eg = '0; found = 1'b0; gi = 0;
      if (en) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            int i = (m_ptr + k) % NUM_REQ;
            if (!found && rv[i]) begin found = 1'b1; gi = i; end
         end
      end
      if (found) eg[gi] = 1'b1;
      last_ready = bus.ReqReady;
      chk("req_ready", 64'(last_ready), 64'(eg));
      @(posedge Clock); n++; #1;
      exp_piv = 1'b0;
      if (found) begin
         q.push_back('{due: n + 1 + DELAY, idx: gi, data: rd[32*gi +: 32]});
         m_inflight++;
         m_ptr = (gi + 1) % NUM_REQ;
         exp_piv = 1'b1;
         m_pin_data = rd[32*gi +: 32];
      end else if (DUMMY && en && rv == '0) begin
         exp_piv = 1'b1;
         m_pin_data = '0;
      end
      exp_rv = '0;
      if (q.size() > 0 && q[0].due == n) begin
         exp_rv[q[0].idx] = 1'b1;
         m_resp_data = q[0].data;
         m_inflight--;
         void'(q.pop_front());
      end
      chk("pipe_in_valid", 64'(PipeInValid), 64'(exp_piv));
      chk("pipe_in_data", 64'(PipeInData), 64'(m_pin_data));
      chk("resp_valid", 64'(bus.RespValid), 64'(exp_rv));
      chk("resp_data", 64'(bus.RespData), 64'(m_resp_data));
      chk("in_flight", 64'(InFlight), 64'(m_inflight));
      chk("busy", 64'(Busy), 64'(m_inflight != 0));
      chk("error", 64'(Error), 64'(m_err));
      if (int'(InFlight) > peak) peak = int'(InFlight);
   endtask

   task automatic idle(input int cycles);
      for (int c = 0; c < cycles; c++) step(1'b0, '0, '0);
   endtask

   function automatic logic [32*NUM_REQ-1:0] rand_data();
      logic [32*NUM_REQ-1:0] d;
      for (int i = 0; i < NUM_REQ; i++) d[32*i +: 32] = $urandom;
      return d;
   endfunction

   initial begin
      logic [32*NUM_REQ-1:0] rd;
      tbl[0] = '{1'b1, 4'b0100, 4'b0100};
      tbl[1] = '{1'b1, 4'b1111, 4'b1000};
      tbl[2] = '{1'b0, 4'b1111, 4'b0000};
      tbl[3] = '{1'b1, 4'b0000, 4'b0000};
      tbl[4] = '{1'b1, 4'b1010, 4'b0010};
      tbl[5] = '{1'b1, 4'b0011, 4'b0001};
      tbl[6] = '{1'b1, 4'b1111, 4'b0010};
      tbl[7] = '{1'b1, 4'b1001, 4'b1000};

      bus.ReqValid = '0; bus.ReqData = '0;
      repeat (DELAY + 2) @(posedge Clock);
      #1;
      chk("rst_ready", 64'(bus.ReqReady), 64'(0));
      chk("rst_pin_data", 64'(PipeInData), 64'(0));
      chk("rst_pin_valid", 64'(PipeInValid), 64'(0));
      chk("rst_resp_valid", 64'(bus.RespValid), 64'(0));
      chk("rst_resp_data", 64'(bus.RespData), 64'(0));
      chk("rst_in_flight", 64'(InFlight), 64'(0));
      chk("rst_busy", 64'(Busy), 64'(0));
      chk("rst_error", 64'(Error), 64'(0));
      @(negedge Clock); Reset_n = 1'b1;
      model_clear();

      for (int i = 0; i < 8; i++) begin
         step(tbl[i].en, tbl[i].rv, rand_data());
         chk("tbl_grant", 64'(last_ready), 64'(tbl[i].exp_ready));
      end
      idle(DELAY + 3);

      // Single request, full latency walk.
      rd = rand_data();
      rd[95:64] = 32'hDEADBEEF;
      step(1'b1, 4'b0100, rd);
      chk("single_ready", 64'(last_ready), 64'(4'b0100));
      chk("single_piv", 64'(PipeInValid), 64'(1));
      chk("single_pid", 64'(PipeInData), 64'(32'hDEADBEEF));
      chk("single_inflight", 64'(InFlight), 64'(1));
      for (int j = 1; j <= DELAY + 1; j++) begin
         step(1'b0, '0, '0);
         if (j < DELAY + 1) begin
            chk("single_wait_rv", 64'(bus.RespValid), 64'(0));
            chk("single_wait_if", 64'(InFlight), 64'(1));
         end else begin
            chk("single_rv", 64'(bus.RespValid), 64'(4'b0100));
            chk("single_rd", 64'(bus.RespData), 64'(32'hDEADBEEF));
            chk("single_if_done", 64'(InFlight), 64'(0));
         end
      end

      // Return pointer to 0, then fairness burst.
      step(1'b1, 4'b1000, rand_data());
      idle(DELAY + 3);
      peak = 0;
      for (int k = 0; k < 8; k++) begin
         step(1'b1, 4'b1111, rand_data());
         chk("fair_grant", 64'(last_ready), 64'(1 << (k % NUM_REQ)));
      end
      idle(DELAY + 3);
      chk("fair_peak", 64'(peak), 64'(DELAY + 1));

      // Enable gating with words in flight.
      step(1'b1, 4'b1111, rand_data());
      step(1'b1, 4'b1111, rand_data());
      for (int j = 0; j < DELAY + 3; j++) begin
         step(1'b0, 4'b1111, rand_data());
         chk("gate_ready", 64'(last_ready), 64'(0));
         chk("gate_piv", 64'(PipeInValid), 64'(0));
      end
      idle(DELAY + 3);

      for (int j = 0; j < 400; j++) begin
         step(($urandom % 8) != 0, NUM_REQ'($urandom), rand_data());
      end
      idle(DELAY + 3);

      // Misalignment: pipeline output valid with no word behind it.
      force_ov = 1'b1;
      m_err = 1'b1;
      step(1'b0, '0, '0);
      force_ov = 1'b0;
      chk("mis_resp", 64'(bus.RespValid), 64'(0));
      for (int j = 0; j < 4; j++) begin
         step(1'b0, '0, '0);
         chk("mis_sticky", 64'(Error), 64'(1));
      end

      // Reset with three words in flight; stale pipeline data must be ignored.
      step(1'b1, 4'b1111, rand_data());
      step(1'b1, 4'b1111, rand_data());
      step(1'b1, 4'b1111, rand_data());
      chk("pre_rst_if", 64'(InFlight), 64'(3));
      #3;
      Reset_n = 1'b0;
      stale_inject = 1'b1;
      Enable = 1'b0; bus.ReqValid = '0;
      #1;
      chk("midrst_if", 64'(InFlight), 64'(0));
      chk("midrst_rv", 64'(bus.RespValid), 64'(0));
      chk("midrst_piv", 64'(PipeInValid), 64'(0));
      chk("midrst_err", 64'(Error), 64'(0));
      model_clear();
      repeat (DELAY + 2) @(posedge Clock);
      @(negedge Clock);
      Reset_n = 1'b1;
      stale_inject = 1'b0;
      for (int j = 0; j < DELAY + 4; j++) begin
         step(1'b0, '0, '0);
         chk("warm_rv", 64'(bus.RespValid), 64'(0));
         chk("warm_err", 64'(Error), 64'(0));
      end

`ifdef OBLIV_DUMMY_EN
      for (int j = 0; j < 10; j++) begin
         step(1'b1, '0, '0);
         chk("dummy_piv", 64'(PipeInValid), 64'(1));
         chk("dummy_pid", 64'(PipeInData), 64'(0));
         chk("dummy_if", 64'(InFlight), 64'(0));
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish (cycle %0d)", n);
      $fatal(1);
   end

endmodule
